// File: rtl/des_pkg.sv
// DES S-box and P-permutation constants plus lookup helpers shared by the
// substitution stage and its per-box LUTs.
package des_pkg;

  typedef logic [1:8][0:63][3:0] sbox_tbl_t;

  // FIPS 46-3 tables in row-major form: entry index is row*16 + col.
  localparam sbox_tbl_t SBOX_ROWMAJOR = {
    64'hE4D12FB83A6C5907, 64'h0F74E2D1A6CB9538, 64'h41E8D62BFC973A50, 64'hFC8249175B3EA06D,
    64'hF18E6B34972DC05A, 64'h3D47F28EC01A69B5, 64'h0E7BA4D158C6932F, 64'hD8A13F42B67C05E9,
    64'hA09E63F51DC7B428, 64'hD70934A6285ECBF1, 64'hD6498F30B12C5AE7, 64'h1AD069874FE3B52C,
    64'h7DE3069A1285BC4F, 64'hD8B56F03472C1AE9, 64'hA690CB7DF13E5284, 64'h3F06A1D8945BC72E,
    64'h2C417AB6853FD0E9, 64'hEB2C47D150FA3986, 64'h421BAD78F9C5630E, 64'hB8C71E2D6F09A453,
    64'hC1AF92680D34E75B, 64'hAF427C9561DE0B38, 64'h9EF528C3704A1DB6, 64'h432C95FABE17608D,
    64'h4B2EF08D3C975A61, 64'hD0B7491AE35C2F86, 64'h14BDC37EAF680592, 64'h6BD814A7950FE23C,
    64'hD2846FB1A93E50C7, 64'h1FD8A374C56B0E92, 64'h7B419CE206ADF358, 64'h21E74A8DFC90356B
  };

  // Re-index so the raw 6-bit field abcdef addresses the table directly.
  function automatic sbox_tbl_t fold_sbox(input sbox_tbl_t t);
    sbox_tbl_t  f;
    logic [5:0] raw;
    f = '0;
    for (int b = 1; b <= 8; b++) begin
      for (int i = 0; i < 64; i++) begin
        raw     = 6'(i);
        f[b][i] = t[b][{raw[5], raw[0], raw[4:1]}];
      end
    end
    return f;
  endfunction

  localparam sbox_tbl_t SBOX = fold_sbox(SBOX_ROWMAJOR);

  localparam int unsigned P_PERM [1:32] = '{
    16,  7, 20, 21, 29, 12, 28, 17,  1, 15, 23, 26,  5, 18, 31, 10,
     2,  8, 24, 14, 32, 27,  3,  9, 19, 13, 30,  6, 22, 11,  4, 25
  };

  function automatic logic [3:0] sbox_lookup(input int unsigned box, input logic [5:0] in6);
    return SBOX[box][in6];
  endfunction

  // Bit numbering is 1-based from the MSB, so position p lives at index 33-p.
  function automatic logic [32:1] p_permute(input logic [32:1] x);
    logic [32:1] y;
    y = '0;
    for (int i = 1; i <= 32; i++) begin
      y[33-i] = x[33-P_PERM[i]];
    end
    return y;
  endfunction

endpackage

// File: rtl/des_sbox_lut.sv
// Single combinational DES S-box; BOX selects which of S1..S8 is implemented.
module des_sbox_lut
  import des_pkg::*;
#(
  parameter int unsigned BOX = 1
) (
  input  logic [6:1] in,
  output logic [4:1] out
);

  if (BOX < 1 || BOX > 8) begin : g_bad_box
    $error("des_sbox_lut: BOX must be in 1..8");
  end

  assign out = sbox_lookup(BOX, in);

endmodule

// File: rtl/des_sbox_stage.sv
// Parallel DES S-box layer with optional P permutation, followed by an elastic
// valid/ready register pipeline of PIPE_STAGES stages with bubble collapsing.
module des_sbox_stage
  import des_pkg::*;
#(
  parameter int unsigned NUM_SBOX    = 8,
  parameter int unsigned PIPE_STAGES = 1,
  parameter bit          APPLY_P     = 1'b1
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  input  logic [6*NUM_SBOX:1]                  in_data,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic [4*NUM_SBOX:1]                  out_data,
  output logic [$clog2(PIPE_STAGES+1)-1:0]     occupancy
);

  localparam int unsigned DW    = 4 * NUM_SBOX;
  localparam int unsigned OCC_W = $clog2(PIPE_STAGES + 1);

  if (NUM_SBOX < 1 || NUM_SBOX > 8) begin : g_bad_num
    $error("des_sbox_stage: NUM_SBOX must be in 1..8");
  end
  if (PIPE_STAGES < 1 || PIPE_STAGES > 3) begin : g_bad_pipe
    $error("des_sbox_stage: PIPE_STAGES must be in 1..3");
  end
  if (APPLY_P && NUM_SBOX != 8) begin : g_bad_p
    $error("des_sbox_stage: APPLY_P requires NUM_SBOX == 8");
  end

  logic [DW:1] lut_raw;
  logic [DW:1] lut_data;

  for (genvar k = 1; k <= NUM_SBOX; k++) begin : g_box
    des_sbox_lut #(
      .BOX (k)
    ) u_lut (
      .in  (in_data[6*(NUM_SBOX-k+1) -: 6]),
      .out (lut_raw[4*(NUM_SBOX-k+1) -: 4])
    );
  end

  if (APPLY_P) begin : g_perm
    assign lut_data = p_permute(lut_raw);
  end else begin : g_no_perm
    assign lut_data = lut_raw;
  end

  logic          v_q [1:PIPE_STAGES];
  logic [DW:1]   d_q [1:PIPE_STAGES];
  logic          adv [1:PIPE_STAGES];
  logic [OCC_W-1:0] occ_q, occ_d;
  logic          in_xfer, out_xfer;

  // A stage may load when it is empty or its successor is loading too.
  always_comb begin
    logic chain;
    chain = out_ready;
    for (int i = PIPE_STAGES; i >= 1; i--) begin
      chain  = !v_q[i] || chain;
      adv[i] = chain;
    end
  end

  for (genvar i = 1; i <= PIPE_STAGES; i++) begin : g_stage
    logic        vin;
    logic [DW:1] din;

    if (i == 1) begin : g_first
      assign vin = in_valid;
      assign din = lut_data;
    end else begin : g_next
      assign vin = v_q[i-1];
      assign din = d_q[i-1];
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        v_q[i] <= 1'b0;
        d_q[i] <= '0;
      end else if (adv[i]) begin
        v_q[i] <= vin;
        if (vin) begin
          d_q[i] <= din;
        end
      end
    end
  end

  assign in_ready  = adv[1] && !rst;
  assign out_valid = v_q[PIPE_STAGES];
  assign out_data  = d_q[PIPE_STAGES];
  assign in_xfer   = in_valid && in_ready;
  assign out_xfer  = out_valid && out_ready;

  always_comb begin
    occ_d = occ_q;
    if (in_xfer && !out_xfer) begin
      occ_d = occ_q + 1'b1;
    end else if (out_xfer && !in_xfer) begin
      occ_d = occ_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      occ_q <= '0;
    end else begin
      occ_q <= occ_d;
    end
  end

  assign occupancy = occ_q;

endmodule

// File: tb/tb_des_sbox_stage.sv
// Self-checking bench for des_sbox_stage across three parameter sets.
module tb_des_sbox_stage;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference S-boxes, row-major, index (box-1)*4 + row, nibble col from the MSB.
  localparam logic [63:0] REF_ROWS [0:31] = '{
    64'hE4D12FB83A6C5907, 64'h0F74E2D1A6CB9538, 64'h41E8D62BFC973A50, 64'hFC8249175B3EA06D,
    64'hF18E6B34972DC05A, 64'h3D47F28EC01A69B5, 64'h0E7BA4D158C6932F, 64'hD8A13F42B67C05E9,
    64'hA09E63F51DC7B428, 64'hD70934A6285ECBF1, 64'hD6498F30B12C5AE7, 64'h1AD069874FE3B52C,
    64'h7DE3069A1285BC4F, 64'hD8B56F03472C1AE9, 64'hA690CB7DF13E5284, 64'h3F06A1D8945BC72E,
    64'h2C417AB6853FD0E9, 64'hEB2C47D150FA3986, 64'h421BAD78F9C5630E, 64'hB8C71E2D6F09A453,
    64'hC1AF92680D34E75B, 64'hAF427C9561DE0B38, 64'h9EF528C3704A1DB6, 64'h432C95FABE17608D,
    64'h4B2EF08D3C975A61, 64'hD0B7491AE35C2F86, 64'h14BDC37EAF680592, 64'h6BD814A7950FE23C,
    64'hD2846FB1A93E50C7, 64'h1FD8A374C56B0E92, 64'h7B419CE206ADF358, 64'h21E74A8DFC90356B
  };
  localparam int REF_P [0:31] = '{
    16,  7, 20, 21, 29, 12, 28, 17,  1, 15, 23, 26,  5, 18, 31, 10,
     2,  8, 24, 14, 32, 27,  3,  9, 19, 13, 30,  6, 22, 11,  4, 25
  };

  function automatic logic [3:0] ref_box(input int box, input logic [5:0] x);
    logic [63:0] r;
    int row, col;
    row = int'({x[5], x[0]});
    col = int'(x[4:1]);
    r   = REF_ROWS[(box-1)*4 + row];
    return r[63-4*col -: 4];
  endfunction

  function automatic logic [31:0] ref_slayer8(input logic [47:0] x);
    logic [31:0] y;
    for (int k = 0; k < 8; k++) y[31-4*k -: 4] = ref_box(k+1, x[47-6*k -: 6]);
    return y;
  endfunction

  function automatic logic [31:0] ref_p(input logic [31:0] x);
    logic [31:0] y;
    for (int i = 0; i < 32; i++) y[31-i] = x[32-REF_P[i]];
    return y;
  endfunction

  function automatic logic [47:0] rand48();
    return {16'($urandom), 32'($urandom)};
  endfunction

  // DUT a: 8 boxes, 1 stage, no P.
  logic a_iv, a_ir, a_ov, a_or;
  logic [48:1] a_id;
  logic [32:1] a_od;
  logic [0:0]  a_occ;
  des_sbox_stage #(.NUM_SBOX(8), .PIPE_STAGES(1), .APPLY_P(1'b0)) u_a (
    .clk(clk), .rst(rst), .in_valid(a_iv), .in_ready(a_ir), .in_data(a_id),
    .out_valid(a_ov), .out_ready(a_or), .out_data(a_od), .occupancy(a_occ)
  );

  // DUT b: 8 boxes, 3 stages, with P.
  logic b_iv, b_ir, b_ov, b_or;
  logic [48:1] b_id;
  logic [32:1] b_od;
  logic [1:0]  b_occ;
  des_sbox_stage #(.NUM_SBOX(8), .PIPE_STAGES(3), .APPLY_P(1'b1)) u_b (
    .clk(clk), .rst(rst), .in_valid(b_iv), .in_ready(b_ir), .in_data(b_id),
    .out_valid(b_ov), .out_ready(b_or), .out_data(b_od), .occupancy(b_occ)
  );

  // DUT c: single box, 2 stages.
  logic c_iv, c_ir, c_ov, c_or;
  logic [6:1] c_id;
  logic [4:1] c_od;
  logic [1:0] c_occ;
  des_sbox_stage #(.NUM_SBOX(1), .PIPE_STAGES(2), .APPLY_P(1'b0)) u_c (
    .clk(clk), .rst(rst), .in_valid(c_iv), .in_ready(c_ir), .in_data(c_id),
    .out_valid(c_ov), .out_ready(c_or), .out_data(c_od), .occupancy(c_occ)
  );

  // Scoreboard for DUT b, sampled on the falling edge.
  logic [31:0] exp_q [$];
  int          b_acc = 0, b_del = 0;
  logic        stall_prev = 1'b0;
  logic [32:1] held;

  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      stall_prev = 1'b0;
    end else begin
      check("b_occupancy", 64'(b_occ), 64'(exp_q.size()));
      if (stall_prev) begin
        check("b_hold_valid", 64'(b_ov), 64'd1);
        check("b_hold_data", 64'(b_od), 64'(held));
      end
      if (b_ov && b_or) begin
        if (exp_q.size() == 0) check("b_spurious_out", 64'(b_ov), 64'd0);
        else begin
          check("b_out_data", 64'(b_od), 64'(exp_q.pop_front()));
          b_del++;
        end
      end
      if (b_iv && b_ir) begin
        exp_q.push_back(ref_p(ref_slayer8(b_id)));
        b_acc++;
      end
      stall_prev = b_ov && !b_or;
      held       = b_od;
    end
  end

  logic [3:0] c_got [$];
  always @(negedge clk) if (!rst && c_ov && c_or) c_got.push_back(c_od);

  task automatic push_b(input logic [47:0] x);
    int t;
    b_iv = 1'b1;
    b_id = x;
    for (t = 0; t < 50; t++) begin
      @(negedge clk);
      if (b_ir) break;
    end
    if (t == 50) check("b_push_timeout", 64'(b_ir), 64'd1);
    @(posedge clk);
    #1;
    b_iv = 1'b0;
  endtask

  typedef struct {
    string       name;
    logic [47:0] din;
    logic [31:0] dout;
  } vec_t;

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    vec_t vecs [5];
    int   cnt;
    logic acc;

    vecs[0] = '{"zeros",    48'h000000000000, 32'hEFA72C4D};
    vecs[1] = '{"ones",     48'hFFFFFFFFFFFF, 32'hD9CE3DCB};
    vecs[2] = '{"row1col0", 48'h041041041041, 32'h03DDEAD1};
    vecs[3] = '{"row2col0", 48'h820820820820, 32'h40DA4917};
    vecs[4] = '{"row0col15", 48'h79E79E79E79E, 32'h7A8F9B17};

    rst = 1'b1;
    a_iv = 0; a_or = 1; a_id = '0;
    b_iv = 0; b_or = 1; b_id = '0;
    c_iv = 0; c_or = 1; c_id = '0;
    @(posedge clk);
    @(posedge clk);
    #1;
    check("rst_a_in_ready", 64'(a_ir), 64'd0);
    check("rst_a_out_valid", 64'(a_ov), 64'd0);
    check("rst_a_out_data", 64'(a_od), 64'd0);
    check("rst_a_occupancy", 64'(a_occ), 64'd0);
    check("rst_b_in_ready", 64'(b_ir), 64'd0);
    rst = 1'b0;
    #1;
    check("empty_a_in_ready", 64'(a_ir), 64'd1);

    // Directed vectors on the one-stage, no-P instance.
    for (int i = 0; i < 5; i++) begin
      a_iv = 1'b1;
      a_id = vecs[i].din;
      @(negedge clk);
      check({vecs[i].name, "_ready"}, 64'(a_ir), 64'd1);
      @(posedge clk);
      #1;
      a_iv = 1'b0;
      check({vecs[i].name, "_valid"}, 64'(a_ov), 64'd1);
      check({vecs[i].name, "_data"}, 64'(a_od), 64'(vecs[i].dout));
      @(posedge clk);
      #1;
      check({vecs[i].name, "_drained"}, 64'(a_ov), 64'd0);
    end

    // Single-box sweep.
    for (int x = 0; x < 64; x++) begin
      c_iv = 1'b1;
      c_id = 6'(x);
      @(posedge clk);
      #1;
    end
    c_iv = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("c_sweep_count", 64'(c_got.size()), 64'd64);
    if (c_got.size() == 64) begin
      check("c_sweep_0", 64'(c_got[0]), 64'd14);
      check("c_sweep_63", 64'(c_got[63]), 64'd13);
      for (int x = 0; x < 64; x++) check("c_sweep", 64'(c_got[x]), 64'(ref_box(1, 6'(x))));
    end

    // Backpressure fill on the three-stage instance.
    b_or = 1'b0;
    cnt  = 0;
    b_iv = 1'b1;
    b_id = rand48();
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      acc = b_ir;
      @(posedge clk);
      #1;
      if (acc) begin
        cnt++;
        b_id = rand48();
      end
    end
    check("fill_accepted", 64'(cnt), 64'd3);
    check("fill_occupancy", 64'(b_occ), 64'd3);
    check("fill_in_ready", 64'(b_ir), 64'd0);
    check("fill_out_valid", 64'(b_ov), 64'd1);
    b_or = 1'b1;
    #1;
    check("full_drain_in_ready", 64'(b_ir), 64'd1);
    @(posedge clk);
    #1;
    check("full_drain_occupancy", 64'(b_occ), 64'd3);
    b_iv = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("fill_empty", 64'(b_occ), 64'd0);

    // 200 random words streamed through P.
    for (int k = 0; k < 200; k++) push_b(rand48());
    repeat (5) @(posedge clk);
    #1;
    check("stream_balance", 64'(b_del), 64'(b_acc));

    // Random handshake toggling.
    for (int k = 0; k < 1000; k++) begin
      b_iv = 1'($urandom_range(0, 1));
      b_or = 1'($urandom_range(0, 1));
      b_id = rand48();
      @(posedge clk);
      #1;
    end
    b_iv = 1'b0;
    b_or = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    check("random_balance", 64'(b_del), 64'(b_acc));
    check("random_empty", 64'(b_occ), 64'd0);

    // Reset with two items in flight.
    b_or = 1'b0;
    push_b(rand48());
    push_b(rand48());
    check("pre_rst_occupancy", 64'(b_occ), 64'd2);
    rst  = 1'b1;
    b_iv = 1'b1;
    #1;
    check("rst_mid_in_ready", 64'(b_ir), 64'd0);
    @(posedge clk);
    #1;
    rst  = 1'b0;
    b_iv = 1'b0;
    check("post_rst_out_valid", 64'(b_ov), 64'd0);
    check("post_rst_out_data", 64'(b_od), 64'd0);
    check("post_rst_occupancy", 64'(b_occ), 64'd0);
    b_or = 1'b1;
    b_iv = 1'b1;
    b_id = 48'h123456789ABC;
    @(negedge clk);
    check("post_rst_in_ready", 64'(b_ir), 64'd1);
    @(posedge clk);
    #1;
    b_iv = 1'b0;
    check("lat_edge1", 64'(b_ov), 64'd0);
    @(posedge clk);
    #1;
    check("lat_edge2", 64'(b_ov), 64'd0);
    @(posedge clk);
    #1;
    check("lat_edge3_valid", 64'(b_ov), 64'd1);
    check("lat_edge3_data", 64'(b_od), 64'(ref_p(ref_slayer8(48'h123456789ABC))));
    repeat (3) @(posedge clk);
    #1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
